// File: rtl/dco_period_meter.sv
// dco_period_meter: measures the half-period of an async square wave in clk
// cycles and decodes it to the DCO one-hot control code.
// Ports: clk, rst (async, active-high), en, sig_in (async wave) ->
//   half_period/code/match (last capture), valid (capture pulse),
//   locked (two equal matching captures), timeout (counter saturated).
module dco_period_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] half_period,
  output logic [7:0]       code,
  output logic             match,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   edge_det;
  logic [CNT_W-1:0]       cnt;
  logic                   have_prev;
  logic [7:0]             dec_code;
  logic                   dec_match;
  logic [31:0]            cnt_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  // Both wave transitions delimit a half-period.
  assign edge_det = sync[SYNC_STAGES-1] ^ prev;

  assign cnt_ext = 32'(cnt);

  // Exact-match decode; 51 is the DCO default setting (code 0x00).
  always_comb begin
    dec_code  = 8'h00;
    dec_match = 1'b1;
    case (cnt_ext)
      32'd4:   dec_code = 8'h01;
      32'd5:   dec_code = 8'h02;
      32'd6:   dec_code = 8'h04;
      32'd7:   dec_code = 8'h08;
      32'd8:   dec_code = 8'h10;
      32'd9:   dec_code = 8'h20;
      32'd10:  dec_code = 8'h40;
      32'd11:  dec_code = 8'h80;
      32'd51:  dec_code = 8'h00;
      default: dec_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      have_prev   <= 1'b0;
      half_period <= '0;
      code        <= 8'h00;
      match       <= 1'b0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ARM;
          end
          ARM: begin
            // Captures never happen here, so clearing every cycle
            // is equivalent to clearing on entry.
            have_prev <= 1'b0;
            if (edge_det) begin
              state <= MEASURE;
              cnt   <= CNT_ONE;
            end
          end
          MEASURE: begin
            if (edge_det) begin
              // Edge wins over saturation on the same cycle.
              half_period <= cnt;
              code        <= dec_code;
              match       <= dec_match;
              valid       <= 1'b1;
              locked      <= dec_match & have_prev &
                             (cnt == half_period);
              have_prev   <= 1'b1;
              cnt         <= CNT_ONE;
            end else if (cnt == CNT_MAX) begin
              timeout <= 1'b1;
              locked  <= 1'b0;
              state   <= ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dco_period_meter.sv
// Directed bench for dco_period_meter: table sweep of half-periods plus
// hand sequences for timeout, enable drop and mid-run reset.
module tb_dco_period_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sig_in;
  logic [7:0] half_period;
  logic [7:0] code;
  logic       match;
  logic       valid;
  logic       locked;
  logic       timeout;

  dco_period_meter #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .half_period(half_period), .code(code), .match(match),
    .valid(valid), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       h;
    bit [7:0] code;
    bit       match;
  } vec_t;

  vec_t vecs[9];

  int applied = 0;
  int miscompares = 0;
  int cycle = 0;
  int nvalid = 0;
  int ntimeout = 0;
  int last_vcyc = 0;
  int last_tcyc = 0;
  bit wave_on = 0;
  bit toggled = 0;
  int ph = 0;
  int hp_drive = 11;

  task automatic chk(input string nm, input int got, input int exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    if (valid) begin
      nvalid++;
      last_vcyc = cycle;
    end
    if (timeout) begin
      ntimeout++;
      last_tcyc = cycle;
    end
    toggled = 0;
    if (wave_on) begin
      ph++;
      if (ph >= hp_drive) begin
        sig_in = ~sig_in;
        ph = 0;
        toggled = 1;
      end
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    while (n < 300 && !ok) begin
      cyc();
      n++;
      if (valid) ok = 1;
    end
    if (!ok) begin
      applied++;
      miscompares++;
      $display("FAIL %s: no valid within 300 cycles", nm);
    end
  endtask

  task automatic wait_toggle();
    int n;
    n = 0;
    cyc();
    while (n < 300 && !toggled) begin
      cyc();
      n++;
    end
    if (!toggled) begin
      applied++;
      miscompares++;
      $display("FAIL wave_toggle: no toggle within 300 cycles");
    end
  endtask

  initial begin
    int t0;
    int nt0;
    int nv0;
    int v1;

    vecs[0] = '{4,  8'h01, 1'b1};
    vecs[1] = '{5,  8'h02, 1'b1};
    vecs[2] = '{6,  8'h04, 1'b1};
    vecs[3] = '{7,  8'h08, 1'b1};
    vecs[4] = '{8,  8'h10, 1'b1};
    vecs[5] = '{9,  8'h20, 1'b1};
    vecs[6] = '{10, 8'h40, 1'b1};
    vecs[7] = '{51, 8'h00, 1'b1};
    vecs[8] = '{20, 8'h00, 1'b0};

    rst = 1'b1;
    en = 1'b0;
    sig_in = 1'b0;
    repeat (3) cyc();
    chk("rst_half_period", half_period, 0);
    chk("rst_code", code, 0);
    chk("rst_match", match, 0);
    chk("rst_valid", valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);

    // H=11 lock-up
    rst = 1'b0;
    en = 1'b1;
    hp_drive = 11;
    ph = 0;
    wave_on = 1;
    wait_valid("h11_first");
    v1 = last_vcyc;
    chk("h11_first_hp", half_period, 11);
    chk("h11_first_locked", locked, 0);
    wait_valid("h11_second");
    chk("h11_spacing", last_vcyc - v1, 11);
    chk("h11_hp", half_period, 11);
    chk("h11_code", code, 8'h80);
    chk("h11_match", match, 1);
    chk("h11_locked", locked, 1);

    // Sweep: change H right after a toggle; the next capture is still
    // the old interval, then two captures of the new one.
    for (int i = 0; i < 9; i++) begin
      wait_toggle();
      hp_drive = vecs[i].h;
      wait_valid("sweep_old");
      wait_valid("sweep_first");
      chk($sformatf("sweep%0d_hp1", vecs[i].h), half_period, vecs[i].h);
      chk($sformatf("sweep%0d_code1", vecs[i].h), code, vecs[i].code);
      chk($sformatf("sweep%0d_match1", vecs[i].h), match, vecs[i].match);
      chk($sformatf("sweep%0d_lock1", vecs[i].h), locked, 0);
      wait_valid("sweep_second");
      chk($sformatf("sweep%0d_hp2", vecs[i].h), half_period, vecs[i].h);
      chk($sformatf("sweep%0d_code2", vecs[i].h), code, vecs[i].code);
      chk($sformatf("sweep%0d_lock2", vecs[i].h), locked, vecs[i].match);
    end

    // Timeout: hold sig_in after one edge
    wait_toggle();
    wave_on = 0;
    wait_valid("to_last_capture");
    t0 = last_vcyc;
    nt0 = ntimeout;
    nv0 = nvalid;
    repeat (300) cyc();
    chk("to_pulses", ntimeout - nt0, 1);
    chk("to_delay", last_tcyc - t0, 255);
    chk("to_no_valid", nvalid - nv0, 0);
    chk("to_locked", locked, 0);
    chk("to_hp_hold", half_period, 20);

    // From ARM: first edge only starts a measurement
    hp_drive = 8;
    ph = 0;
    wave_on = 1;
    wait_valid("h8_first");
    chk("h8_first_hp", half_period, 8);
    chk("h8_first_locked", locked, 0);
    wait_valid("h8_second");
    chk("h8_locked", locked, 1);

    // Enable drop for 3 cycles
    en = 1'b0;
    nv0 = nvalid;
    nt0 = ntimeout;
    repeat (3) cyc();
    chk("en_off_valid", nvalid - nv0, 0);
    chk("en_off_timeout", ntimeout - nt0, 0);
    chk("en_off_locked", locked, 0);
    chk("en_off_hp_hold", half_period, 8);
    en = 1'b1;
    wait_valid("reen_first");
    chk("reen_first_hp", half_period, 8);
    chk("reen_first_locked", locked, 0);
    wait_valid("reen_second");
    chk("reen_second_locked", locked, 1);

    // Async reset mid half-period while locked
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    chk("arst_half_period", half_period, 0);
    chk("arst_code", code, 0);
    chk("arst_match", match, 0);
    chk("arst_locked", locked, 0);
    chk("arst_valid", valid, 0);
    repeat (2) cyc();
    rst = 1'b0;
    // First capture after release may be a partial interval.
    wait_valid("relock_1");
    wait_valid("relock_2");
    wait_valid("relock_3");
    chk("relock_hp", half_period, 8);
    chk("relock_code", code, 8'h10);
    chk("relock_locked", locked, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule

// File: doc/dco_period_meter.md
# dco_period_meter

Receive-side companion to the team's digitally controlled oscillator (DCO). It measures the half-period of an incoming square wave in `clk` cycles and decodes it back into the 8-bit priority DCO control code that produces that half-period. It sits on the loop-back or characterisation path, so the DCO output can be checked on chip without external instruments.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `sig_in`; legal range ≥2.
- `CNT_W`, default 8: width of the half-period counter and the `half_period` output.

Ports:
- `clk` input 1: single clock for the whole block.
- `rst` input 1: reset, asynchronous and active-high; all state is cleared while it is high.
- `en` input 1: measurement enable.
- `sig_in` input 1: asynchronous square wave under test.
- `half_period` output CNT_W: last captured half-period, in `clk` cycles.
- `code` output 8: DCO code decoded from `half_period`.
- `match` output 1: high when `half_period` is a legal DCO half-period.
- `valid` output 1: one-cycle pulse; `half_period`, `code` and `match` were updated on this cycle.
- `locked` output 1: two consecutive captures were equal and `match` was high.
- `timeout` output 1: one-cycle pulse when the counter saturates.

## Operation
- **Synchronizer:** `sig_in` passes through `SYNC_STAGES` flops (reset 0), then one history flop `prev` (reset 0). `edge` = sync output XOR `prev`; both rising and falling transitions count as edges.
- **FSM states:** IDLE, ARM, MEASURE. Reset state is IDLE.
- IDLE → ARM when `en`=1.
- ARM → MEASURE on the first `edge`; `cnt` is loaded with 1.
- MEASURE, `edge` cycle:
  - `half_period` ← `cnt`, `code`/`match` ← decode(`cnt`), `valid` pulses.
  - `cnt` ← 1.
- MEASURE, non-edge cycle: `cnt` ← `cnt`+1.
- MEASURE, `cnt` = 2^CNT_W−1 with no edge: `timeout` pulses, `locked` ← 0, go to ARM. No capture occurs.
- Any state with `en`=0 → IDLE on the next cycle. `locked` ← 0. `half_period`, `code` and `match` hold. No `valid` or `timeout` pulses.
- **Decode** (exact match only). Half-period H = DCO period setting + 1.
  - H=4 → 0x01
  - H=5 → 0x02
  - H=6 → 0x04
  - H=7 → 0x08
  - H=8 → 0x10
  - H=9 → 0x20
  - H=10 → 0x40
  - H=11 → 0x80
  - H=51 → 0x00 (DCO default setting)
  - All of the above give `match`=1.
  - Any other H → `code`=0x00, `match`=0.
  - `code` is the canonical one-hot representative; a DCO driven with any code sharing the same leading one produces the same H.
- **Lock:**
  - On a capture: `locked` ← (`match` of the new value) AND (new H == previous captured H) AND (a previous capture exists since entering ARM).
  - A capture that fails this condition clears `locked`.
  - ARM clears the "previous capture exists" flag.
- **Width rule:** `cnt` is CNT_W bits and never wraps. Saturation is handled only by the timeout path.

## Timing
- Reset values: `half_period`=0, `code`=0x00, `match`=0, `valid`=0, `locked`=0, `timeout`=0. FSM is in IDLE, `cnt`=0, synchronizer and `prev` are 0.
- Latency: a `sig_in` level first sampled at clock edge k gives `edge`=1 in the cycle after edge k+SYNC_STAGES−1. Registered outputs (`valid`, `half_period`, `code`, `match`, `locked`) update at edge k+SYNC_STAGES.
- A steady wave with half-period H `clk` cycles gives `valid` pulses every H cycles with `half_period`=H. The first capture is the first full half-period after ARM; the partial interval before the first edge is never reported.
- `locked` rises together with the second consecutive matching `valid`.
- `timeout` pulses exactly 2^CNT_W−1 cycles after the last edge, or after the ARM→MEASURE transition.
- Simultaneous `edge` and saturation: the edge wins. Capture H = 2^CNT_W−1 (`match`=0) and no timeout.
- `en` falling on an `edge` cycle: no capture.
- `rst` asserted mid-measurement: all outputs clear immediately (asynchronous). After deassertion the block restarts from IDLE.
- Minimum measurable H is 2; H=1 (a toggle every cycle) is outside the supported range.

## Test plan
- Square wave H=11, `en`=1 → after two captures, `half_period`=11, `code`=0x80, `match`=1, `locked`=1, with `valid` every 11 cycles.
- Sweep H=4…10 → `code` = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40 in turn, `match`=1 throughout. `locked` drops on the first capture after each step and re-asserts on the next.
- H=51 → `code`=0x00, `match`=1, `locked`=1. Then H=20 → `code`=0x00, `match`=0, `locked`=0.
- `sig_in` held constant for 300 cycles after one edge → a single `timeout` pulse 255 cycles after that edge, `locked`=0, FSM in ARM, `half_period` unchanged.
- Lock at H=8, then pull `en` low for 3 cycles → `locked`=0, no `valid` pulses. Re-enable → the first `valid` is H=8 with `locked`=0, and the second `valid` gives `locked`=1.
- Assert `rst` mid-half-period while locked → all outputs 0 immediately. After release, locking resumes on the same wave.
